w0rm_peripheral_bus_arbiter: RTL

Round-robin arbiter that shares the single W0RM peripheral bus between `NUM_PORTS` requesters. It replaces fixed-priority valid muxing with an explicit request/grant handshake, so only one port drives the bus at a time. Each grant is held until its owner releases it, and granted beats are registered onto the bus. It sits between bus masters (core load/store unit, DMA, debug) and the peripheral bus fabric.

---
 rtl/w0rm_bus_pkg.sv | 12 +
 rtl/w0rm_rr_pick.sv | 30 +++
 rtl/w0rm_peripheral_bus_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/w0rm_bus_pkg.sv
// Shared types and limits for the W0RM peripheral bus arbiter.
package w0rm_bus_pkg;

  localparam int unsigned W0RM_BUS_PORTS_MAX = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

endpackage

// File: rtl/w0rm_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module w0rm_rr_pick #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr_i,
  output logic [NUM_PORTS-1:0]         grant_o,
  output logic [$clog2(NUM_PORTS)-1:0] idx_o,
  output logic                         any_o
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  always_comb begin
    logic [IdxW-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NUM_PORTS);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/w0rm_peripheral_bus_arbiter.sv
// Round-robin request/grant arbiter for the W0RM peripheral bus with registered beats.
// Optional grant timeout compiled in with W0RM_BUS_ARB_TIMEOUT_EN.
module w0rm_peripheral_bus_arbiter
  import w0rm_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                            bus_clock,
  input  logic                            bus_reset_n,
  input  logic [NUM_PORTS-1:0]            port_req_i,
  input  logic [NUM_PORTS-1:0]            port_valid_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_i,
  output logic [NUM_PORTS-1:0]            port_grant_o,
  output logic                            bus_valid_o,
  output logic [DATA_WIDTH-1:0]           bus_data_o,
  output logic [$clog2(NUM_PORTS)-1:0]    bus_owner_o,
  output logic                            bus_error_o,
  output logic                            timeout_o
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  arb_state_e             state_q;
  logic [IdxW-1:0]        ptr_q, owner_q, pick_idx, next_ptr;
  logic [NUM_PORTS-1:0]   grant_q, pick_grant;
  logic                   pick_any;
  logic                   bus_valid_q, bus_error_q, timeout_q;
  logic [DATA_WIDTH-1:0]  bus_data_q, owner_data;
  logic                   owner_req, owner_valid, hold_expired;

  w0rm_rr_pick #(
    .NUM_PORTS(NUM_PORTS)
  ) u_pick (
    .req_i  (port_req_i),
    .ptr_i  (ptr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    owner_data = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (IdxW'(k) == owner_q) owner_data = port_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_req   = port_req_i[owner_q];
  assign owner_valid = port_valid_i[owner_q];
  assign next_ptr    = (owner_q == IdxW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

`ifdef W0RM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD);
  logic [HoldW-1:0] hold_cnt_q;

  // Zero outside GRANT, so every new tenure starts counting from 0.
  always_ff @(posedge bus_clock or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      hold_cnt_q <= '0;
    end else if (state_q == StGrant) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end else begin
      hold_cnt_q <= '0;
    end
  end

  assign hold_expired = (state_q == StGrant) && (hold_cnt_q == HoldW'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge bus_clock or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      grant_q     <= '0;
      owner_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_error_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // Any beat from a port not currently granted is flagged and dropped.
      bus_error_q <= |(port_valid_i & ~grant_q);
      bus_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            state_q <= StGrant;
            grant_q <= pick_grant;
            owner_q <= pick_idx;
          end
        end
        StGrant: begin
          bus_valid_q <= owner_valid;
          if (owner_valid) bus_data_q <= owner_data;
          if (!owner_req) begin
            state_q <= StRelease;
            grant_q <= '0;
          end else if (hold_expired) begin
            state_q   <= StRelease;
            grant_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        StRelease: begin
          state_q <= StIdle;
          ptr_q   <= next_ptr;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign port_grant_o = grant_q;
  assign bus_valid_o  = bus_valid_q;
  assign bus_data_o   = bus_data_q;
  assign bus_owner_o  = owner_q;
  assign bus_error_o  = bus_error_q;
  assign timeout_o    = timeout_q;

endmodule
